// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 24C256-style EEPROM: two-byte addressing, in-page write
// wrap, a timed internal write cycle that NACKs addressing, and sequential reads.
module i2c_eeprom_target #(
  parameter logic [6:0] SLA7   = 7'h50,
  parameter int         ADDR_W = 10,
  parameter int         PAGE_W = 6,
  parameter int         WR_CYC = 2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              sel,
  output logic              wr_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_MEMH, S_MEMH_ACK, S_MEML, S_MEML_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_scl_s1, r_scl_s2, r_scl_d;
  logic                r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0]          r_bit_cnt;
  logic [6:0]          r_rx;
  logic [6:0]          r_tx;
  logic [ADDR_W-9:0]   r_hi;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_rw;
  logic                r_ack_clk;
  logic                r_wrote;
  logic                r_sel;
  logic                r_sda_oe;
  logic [15:0]         r_wcnt;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_waddr;
  logic [7:0]          r_mem_wdata;
  logic [7:0]          r_mem [0:(1<<ADDR_W)-1];

  logic                w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic                w_start, w_stop, w_last_bit, w_addr_ok, w_busy;
  logic                w_ack_state, w_commit;
  logic [7:0]          w_byte;
  logic [7:0]          w_rd_byte;
  logic [PAGE_W-1:0]   w_page_lo;
  logic [ADDR_W-1:0]   w_ptr_page;
  logic [ADDR_W-1:0]   w_mem_addr;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_sda_rise = r_sda_s2 & ~r_sda_d;
  assign w_sda_fall = ~r_sda_s2 & r_sda_d;
  assign w_start    = r_scl_s2 & r_scl_d & w_sda_fall;
  assign w_stop     = r_scl_s2 & r_scl_d & w_sda_rise;
  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_byte     = {r_rx, r_sda_s2};
  assign w_busy     = (r_wcnt != 16'd0);
  assign w_addr_ok  = (w_byte[7:1] == SLA7) && !w_busy;
  assign w_rd_byte  = r_mem[r_ptr];
  assign w_page_lo  = r_ptr[PAGE_W-1:0] + PAGE_W'(1);
  assign w_ptr_page = {r_ptr[ADDR_W-1:PAGE_W], w_page_lo};
  assign w_mem_addr = {r_hi, w_byte};
  assign w_ack_state = (r_state == S_ADDR_ACK) || (r_state == S_MEMH_ACK) ||
                       (r_state == S_MEML_ACK) || (r_state == S_WDATA_ACK);
  assign w_commit   = !reset && !w_start && !w_stop && w_scl_rise &&
                      (r_state == S_WDATA) && w_last_bit;

  // mem_we is a single-cycle strobe; mem_waddr/mem_wdata are meaningful only while it is high.
  assign sda_oe    = r_sda_oe;
  assign sel       = r_sel;
  assign wr_busy   = w_busy;
  assign mem_we    = r_mem_we;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Bus conditions override everything; otherwise SCL edges advance the byte/ACK phases.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_scl_rise) begin
      case (r_state)
        S_ADDR:      if (w_last_bit) w_state_nxt = w_addr_ok ? S_ADDR_ACK : S_IGNORE;
        S_MEMH:      if (w_last_bit) w_state_nxt = S_MEMH_ACK;
        S_MEML:      if (w_last_bit) w_state_nxt = S_MEML_ACK;
        S_WDATA:     if (w_last_bit) w_state_nxt = S_WDATA_ACK;
        S_RDATA:     if (w_last_bit) w_state_nxt = S_RDATA_ACK;
        S_RDATA_ACK: if (r_sda_s2)   w_state_nxt = S_IGNORE;
        default:     w_state_nxt = r_state;
      endcase
    end else if (w_scl_fall && r_ack_clk) begin
      case (r_state)
        S_ADDR_ACK:  w_state_nxt = r_rw ? S_RDATA : S_MEMH;
        S_MEMH_ACK:  w_state_nxt = S_MEML;
        S_MEML_ACK:  w_state_nxt = S_WDATA;
        S_WDATA_ACK: w_state_nxt = S_WDATA;
        S_RDATA_ACK: w_state_nxt = S_RDATA;
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt   <= 3'd0;
      r_rx        <= 7'd0;
      r_tx        <= 7'd0;
      r_hi        <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_ack_clk   <= 1'b0;
      r_wrote     <= 1'b0;
      r_sel       <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_wcnt      <= 16'd0;
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= 8'd0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_stop && r_wrote) r_wcnt <= 16'(WR_CYC);
      else if (w_busy)       r_wcnt <= r_wcnt - 16'd1;

      if (w_start) begin
        r_bit_cnt <= 3'd0;
        r_sda_oe  <= 1'b0;
        r_sel     <= 1'b0;
        r_wrote   <= 1'b0;
      end else if (w_stop) begin
        r_sda_oe  <= 1'b0;
        r_sel     <= 1'b0;
        r_wrote   <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          S_ADDR, S_MEMH, S_MEML, S_WDATA: begin
            r_rx      <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              r_ack_clk <= 1'b0;
              case (r_state)
                S_ADDR: begin
                  r_rw  <= w_byte[0];
                  r_sel <= w_addr_ok;
                end
                S_MEMH: r_hi  <= w_byte[ADDR_W-9:0];
                S_MEML: r_ptr <= w_mem_addr;
                default: begin
                  r_mem_we    <= 1'b1;
                  r_mem_waddr <= r_ptr;
                  r_mem_wdata <= w_byte;
                  r_ptr       <= w_ptr_page;
                  r_wrote     <= 1'b1;
                end
              endcase
            end
          end
          S_ADDR_ACK, S_MEMH_ACK, S_MEML_ACK, S_WDATA_ACK: r_ack_clk <= 1'b1;
          S_RDATA: begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_last_bit) r_ack_clk <= 1'b0;
          end
          S_RDATA_ACK: begin
            if (!r_sda_s2) begin
              r_ptr     <= r_ptr + ADDR_W'(1);
              r_ack_clk <= 1'b1;
            end else begin
              r_sel     <= 1'b0;
            end
          end
          default: r_bit_cnt <= r_bit_cnt;
        endcase
      end else if (w_scl_fall) begin
        // The byte is transmitted inverted onto the open-drain enable, MSB first.
        if (w_ack_state) begin
          if (!r_ack_clk) begin
            r_sda_oe <= 1'b1;
          end else if (r_state == S_ADDR_ACK && r_rw) begin
            r_tx     <= w_rd_byte[6:0];
            r_sda_oe <= ~w_rd_byte[7];
          end else begin
            r_sda_oe <= 1'b0;
          end
        end else if (r_state == S_RDATA) begin
          r_tx     <= {r_tx[5:0], 1'b0};
          r_sda_oe <= ~r_tx[6];
        end else if (r_state == S_RDATA_ACK) begin
          if (!r_ack_clk) begin
            r_sda_oe <= 1'b0;
          end else begin
            r_tx     <= w_rd_byte[6:0];
            r_sda_oe <= ~w_rd_byte[7];
          end
        end
      end
    end
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[r_ptr] <= w_byte;
  end

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Bench for i2c_eeprom_target: a bit-level I2C initiator plus a memory/pointer model
// that predicts read data, ACKs, committed bytes and write-cycle behaviour.
module tb_i2c_eeprom_target;
  localparam int ADDR_W = 10;
  localparam int Q      = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;
  logic sda_oe, sel, wr_busy, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [3:0] dbg_state;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_target dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oe(sda_oe), .sel(sel), .wr_busy(wr_busy), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] exp_q[$];
  logic [7:0]  mem_m [0:1023];
  int          ptr_m = 0;
  bit          exp_quiet = 1'b0;
  logic [ADDR_W-1:0] last_waddr = '0;
  logic [7:0]  last_wdata = 8'd0;
  logic [7:0]  rd_last = 8'd0;
  int          busy_run = 0;
  int          last_run = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Compare process: every commit must match the model's queue; SDA must stay released when told.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      last_waddr = mem_waddr;
      last_wdata = mem_wdata;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_commit: got addr 0x%0h data 0x%0h, required no commit", mem_waddr, mem_wdata);
      end else begin
        check("commit", {mem_waddr, mem_wdata}, {14'd0, exp_q.pop_front()});
      end
    end
    if (exp_quiet) check("sda_quiet", sda_oe, 1'b0);
    if (wr_busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input bit b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2*Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack, output bit sel_s);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack   = ~sda_bus;
    sel_s = sel;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic recv_byte(input bit master_ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tick(Q);
      scl_m = 1'b1; tick(Q);
      b[i]  = sda_bus;
      tick(Q);
      scl_m = 1'b0; tick(Q);
    end
    sda_m = master_ack ? 1'b0 : 1'b1; tick(Q);
    scl_m = 1'b1; tick(2*Q);
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b1;
  endtask

  task automatic set_pointer(input logic [15:0] a);
    bit ack, s;
    bus_start();
    send_byte(8'hA0, ack, s); check("wr_addr_ack", ack, 1'b1);
    send_byte(a[15:8], ack, s); check("memh_ack", ack, 1'b1);
    send_byte(a[7:0], ack, s);  check("meml_ack", ack, 1'b1);
    ptr_m = a % 1024;
  endtask

  // Data bytes are taken MSB-first from the packed word; the pointer wraps inside a 64-byte page.
  task automatic wr_txn(input logic [15:0] a, input int n, input logic [31:0] data);
    bit ack, s;
    logic [7:0] d;
    set_pointer(a);
    for (int i = 0; i < n; i++) begin
      d = data[31-8*i -: 8];
      exp_q.push_back({ptr_m[ADDR_W-1:0], d});
      mem_m[ptr_m] = d;
      ptr_m = (ptr_m / 64) * 64 + ((ptr_m + 1) % 64);
      send_byte(d, ack, s);
      check("wdata_ack", ack, 1'b1);
    end
    bus_stop();
  endtask

  task automatic rd_txn(input logic [15:0] a, input int n);
    bit ack, s;
    logic [7:0] b;
    set_pointer(a);
    bus_start();
    send_byte(8'hA1, ack, s); check("rd_addr_ack", ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, b);
      check("rd_data", b, mem_m[ptr_m]);
      rd_last = b;
      if (i < n - 1) ptr_m = (ptr_m + 1) % 1024;
    end
    bus_stop();
  endtask

  task automatic wait_not_busy();
    int t = 0;
    while (wr_busy && t < 5000) begin
      tick(1);
      t++;
    end
    check("busy_timeout", wr_busy, 1'b0);
    tick(2);
  endtask

  initial begin
    bit ack, s;
    logic [7:0] b;
    reset = 1'b1; tick(4);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_sel", sel, 1'b0);
    check("rst_wr_busy", wr_busy, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_waddr", mem_waddr, 10'h000);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    reset = 1'b0; ptr_m = 0; tick(4);

    wr_txn(16'h0010, 4, 32'hDEADBEEF);
    check("page_last_addr", last_waddr, 10'h013);
    check("page_last_data", last_wdata, 8'hEF);
    check("busy_after_stop", wr_busy, 1'b1);

    exp_quiet = 1'b1;
    bus_start();
    send_byte(8'hA0, ack, s);
    exp_quiet = 1'b0;
    check("poll_nack", ack, 1'b0);
    check("poll_sel", s, 1'b0);
    bus_stop();
    check("poll_still_busy", wr_busy, 1'b1);
    wait_not_busy();
    check("busy_len", last_run, 2000);

    bus_start();
    send_byte(8'hA0, ack, s);
    check("poll_ack", ack, 1'b1);
    check("poll_sel_hi", s, 1'b1);
    bus_stop();
    tick(20);
    check("addr_only_no_wc", wr_busy, 1'b0);

    rd_txn(16'h0012, 1);
    check("rand_read_lit", rd_last, 8'hBE);
    tick(20);
    check("read_no_wc", wr_busy, 1'b0);

    wr_txn(16'h003F, 3, 32'h11223300);
    check("wrap_last_addr", last_waddr, 10'h001);
    check("wrap_last_data", last_wdata, 8'h33);
    wait_not_busy();
    wr_txn(16'h03FF, 1, 32'h5A000000);
    wait_not_busy();

    rd_txn(16'h03FF, 2);
    check("seq_wrap_lit", rd_last, 8'h22);

    exp_quiet = 1'b1;
    bus_start();
    send_byte(8'hA2, ack, s);
    check("mismatch_nack", ack, 1'b0);
    check("mismatch_sel", s, 1'b0);
    send_byte(8'h55, ack, s);
    check("mismatch_ignored", ack, 1'b0);
    bus_stop();
    exp_quiet = 1'b0;

    set_pointer(16'h0020);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_stop();
    tick(20);
    check("abort_no_wc", wr_busy, 1'b0);
    check("abort_sel", sel, 1'b0);

    set_pointer(16'h0001);
    bus_start();
    send_byte(8'hA1, ack, s);
    check("rst_rd_ack", ack, 1'b1);
    check("rdata_drive", sda_oe, 1'b1);
    reset = 1'b1; tick(1);
    check("reset_release", sda_oe, 1'b0);
    tick(2);
    reset = 1'b0; ptr_m = 0; tick(4);
    bus_stop();
    tick(10);

    bus_start();
    send_byte(8'hA1, ack, s);
    check("cur_rd_ack", ack, 1'b1);
    recv_byte(1'b0, b);
    check("cur_rd_data", b, mem_m[ptr_m]);
    check("cur_rd_lit", b, 8'h22);
    bus_stop();
    tick(20);

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
